// File: rtl/vthernet_pkg.sv
// Shared definitions for the vthernet receive path: byte width, RX FSM encoding
// and the slot/length width helpers used by rx_udp, rx_udp_demux and wb_interface.
package vthernet_pkg;

   localparam int unsigned OCT = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECV    = 2'd1,
      ST_DISCARD = 2'd2
   } rx_state_e;

   // A slot length must be able to hold the full 2^addr_w byte count.
   function automatic int unsigned len_w(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

   function automatic int unsigned mem_addr_w(input int unsigned ch_w, input int unsigned addr_w);
      return ch_w + 1 + addr_w;
   endfunction

endpackage

// File: rtl/udp_port_match.sv
// Priority match of a UDP destination port against the enabled channel ports;
// the lowest matching channel index wins.
module udp_port_match
   import vthernet_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic [16*NUM_CH-1:0] ch_port,
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic [15:0]          dst_port,
   output logic                 hit,
   output logic [CH_W-1:0]      ch_idx
);

   // Scan from the top so the lowest index is the last to overwrite.
   always_comb begin
      hit    = 1'b0;
      ch_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_en[i] && (ch_port[16*i +: 16] == dst_port)) begin
            hit    = 1'b1;
            ch_idx = CH_W'(i);
         end
      end
   end

endmodule

// File: rtl/rx_udp_demux.sv
// UDP receive demultiplexer: steers payload bytes by destination port into a
// per-channel ping-pong slot pair in SRAM, committing only complete good frames.
module rx_udp_demux
   import vthernet_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic                     RX_CLK,
   input  logic                     rst,
   input  logic [16*NUM_CH-1:0]     ch_port,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [15:0]              rx_dst_port,
   input  logic                     rx_udp_data_v,
   input  logic [OCT-1:0]           rx_udp_data,
   input  logic                     rx_udp_err,
   output logic                     mem_we,
   output logic [CH_W+ADDR_W:0]     mem_addr,
   output logic [OCT-1:0]           mem_wdata,
   input  logic [CH_W-1:0]          rd_ch,
   input  logic                     rd_done,
   output logic                     rd_slot,
   output logic [ADDR_W:0]          rd_len,
   output logic [NUM_CH-1:0]        ch_avail,
   output logic [NUM_CH-1:0]        ch_irq,
   output logic [15:0]              drop_cnt
);

   localparam int unsigned LEN_W   = len_w(ADDR_W);
   localparam int unsigned MADDR_W = mem_addr_w(CH_W, ADDR_W);
   localparam logic [LEN_W-1:0] SLOT_BYTES = LEN_W'(2**ADDR_W);

   rx_state_e          state;
   logic [CH_W-1:0]    cur_ch;
   logic               cur_slot;
   logic [LEN_W-1:0]   cnt;
   logic               bad;
   logic               v_q;

   logic [NUM_CH-1:0]  wr_slot_q;
   logic [NUM_CH-1:0]  rd_slot_q;
   logic [1:0]         full_q [NUM_CH];
   logic [LEN_W-1:0]   len_q  [NUM_CH][2];

   logic               hit;
   logic [CH_W-1:0]    match_ch;
   logic [15:0]        drop_next;
   logic               frame_start;

   udp_port_match #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_match (
      .ch_port  (ch_port),
      .ch_en    (ch_en),
      .dst_port (rx_dst_port),
      .hit      (hit),
      .ch_idx   (match_ch)
   );

   // A frame only starts on a rising edge of the valid run, so a run cut by reset is ignored.
   assign frame_start = rx_udp_data_v && !v_q;
   assign drop_next   = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;

   assign rd_slot = rd_slot_q[rd_ch];
   assign rd_len  = len_q[rd_ch][rd_slot_q[rd_ch]];

   always_comb begin
      ch_avail = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_avail[c] = |full_q[c];
      end
   end

   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state     <= ST_IDLE;
         cur_ch    <= '0;
         cur_slot  <= 1'b0;
         cnt       <= '0;
         bad       <= 1'b0;
         v_q       <= rx_udp_data_v;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ch_irq    <= '0;
         drop_cnt  <= '0;
         wr_slot_q <= '0;
         rd_slot_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            full_q[c]    <= 2'b00;
            len_q[c][0]  <= '0;
            len_q[c][1]  <= '0;
         end
      end else begin
         v_q    <= rx_udp_data_v;
         mem_we <= 1'b0;
         ch_irq <= '0;

         // Release never collides with a commit: the released slot is full, the committing one is not.
         if (rd_done && (|full_q[rd_ch])) begin
            full_q[rd_ch][rd_slot_q[rd_ch]] <= 1'b0;
            rd_slot_q[rd_ch]                <= ~rd_slot_q[rd_ch];
         end

         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  if (!hit) begin
                     state <= ST_DISCARD;
                  end else if (full_q[match_ch][wr_slot_q[match_ch]]) begin
                     state    <= ST_DISCARD;
                     drop_cnt <= drop_next;
                  end else begin
                     state     <= ST_RECV;
                     cur_ch    <= match_ch;
                     cur_slot  <= wr_slot_q[match_ch];
                     mem_we    <= 1'b1;
                     mem_addr  <= MADDR_W'({match_ch, wr_slot_q[match_ch], ADDR_W'(0)});
                     mem_wdata <= rx_udp_data;
                     cnt       <= LEN_W'(1);
                     bad       <= rx_udp_err;
                  end
               end
            end

            ST_RECV: begin
               if (rx_udp_data_v) begin
                  bad <= bad | rx_udp_err;
                  if (cnt == SLOT_BYTES) begin
                     state    <= ST_DISCARD;
                     drop_cnt <= drop_next;
                  end else begin
                     mem_we    <= 1'b1;
                     mem_addr  <= MADDR_W'({cur_ch, cur_slot, cnt[ADDR_W-1:0]});
                     mem_wdata <= rx_udp_data;
                     cnt       <= cnt + LEN_W'(1);
                  end
               end else begin
                  state <= ST_IDLE;
                  if (bad) begin
                     drop_cnt <= drop_next;
                  end else begin
                     full_q[cur_ch][cur_slot] <= 1'b1;
                     len_q[cur_ch][cur_slot]  <= cnt;
                     wr_slot_q[cur_ch]        <= ~wr_slot_q[cur_ch];
                     ch_irq[cur_ch]           <= 1'b1;
                  end
               end
            end

            ST_DISCARD: begin
               if (!rx_udp_data_v) begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_udp_demux.sv
// Scoreboard bench for rx_udp_demux: a full-size instance checked write-by-write
// and a 16-byte-slot instance for the frame length boundary.
module tb_rx_udp_demux;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CH_W   = 2;
   localparam int unsigned AW     = 11;
   localparam int unsigned AW_S   = 4;

   logic                 RX_CLK = 1'b0;
   logic                 rst = 1'b1;
   logic [16*NUM_CH-1:0] ch_port = '0;
   logic [NUM_CH-1:0]    ch_en = '0;
   logic [NUM_CH-1:0]    ch_en_s = '0;
   logic [15:0]          rx_dst_port = '0;
   logic                 rx_udp_data_v = 1'b0;
   logic [7:0]           rx_udp_data = '0;
   logic                 rx_udp_err = 1'b0;
   logic [CH_W-1:0]      rd_ch = '0;
   logic                 rd_done = 1'b0;

   logic                 mem_we, mem_we_s;
   logic [CH_W+AW:0]     mem_addr;
   logic [CH_W+AW_S:0]   mem_addr_s;
   logic [7:0]           mem_wdata, mem_wdata_s;
   logic                 rd_slot, rd_slot_s;
   logic [AW:0]          rd_len;
   logic [AW_S:0]        rd_len_s;
   logic [NUM_CH-1:0]    ch_avail, ch_avail_s, ch_irq, ch_irq_s;
   logic [15:0]          drop_cnt, drop_cnt_s;

   typedef struct packed {
      logic [CH_W+AW:0] addr;
      logic [7:0]       data;
   } wr_t;

   wr_t wq[$];
   int  iq[$];
   int  total = 0;
   int  bad = 0;
   int  s_we_cnt = 0;
   int  s_irq_cnt = 0;

   always #5 RX_CLK = ~RX_CLK;

   rx_udp_demux #(.NUM_CH(NUM_CH), .ADDR_W(AW)) dut (
      .RX_CLK(RX_CLK), .rst(rst), .ch_port(ch_port), .ch_en(ch_en),
      .rx_dst_port(rx_dst_port), .rx_udp_data_v(rx_udp_data_v),
      .rx_udp_data(rx_udp_data), .rx_udp_err(rx_udp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rd_ch(rd_ch), .rd_done(rd_done), .rd_slot(rd_slot), .rd_len(rd_len),
      .ch_avail(ch_avail), .ch_irq(ch_irq), .drop_cnt(drop_cnt)
   );

   rx_udp_demux #(.NUM_CH(NUM_CH), .ADDR_W(AW_S)) dut_s (
      .RX_CLK(RX_CLK), .rst(rst), .ch_port(ch_port), .ch_en(ch_en_s),
      .rx_dst_port(rx_dst_port), .rx_udp_data_v(rx_udp_data_v),
      .rx_udp_data(rx_udp_data), .rx_udp_err(rx_udp_err),
      .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
      .rd_ch(rd_ch), .rd_done(rd_done), .rd_slot(rd_slot_s), .rd_len(rd_len_s),
      .ch_avail(ch_avail_s), .ch_irq(ch_irq_s), .drop_cnt(drop_cnt_s)
   );

   // Monitor: every write and every irq pulse of the main instance must match the queue head.
   always @(negedge RX_CLK) begin
      wr_t e;
      int  ec;
      if (mem_we) begin
         total++;
         if (wq.size() == 0) begin
            bad++;
            $display("FAIL write_unexpected got addr=%h data=%h required no write", mem_addr, mem_wdata);
         end else begin
            e = wq.pop_front();
            if (e.addr !== mem_addr || e.data !== mem_wdata) begin
               bad++;
               $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
      if (ch_irq != '0) begin
         total++;
         if (iq.size() == 0) begin
            bad++;
            $display("FAIL irq_unexpected got %b required none", ch_irq);
         end else begin
            ec = iq.pop_front();
            if (ch_irq !== NUM_CH'(1 << ec)) begin
               bad++;
               $display("FAIL irq got %b required channel %0d", ch_irq, ec);
            end
         end
      end
      if (mem_we_s) s_we_cnt++;
      if (ch_irq_s != '0) s_irq_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge RX_CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      rx_udp_data_v = 1'b0;
      rd_done = 1'b0;
      idle(2);
      rst = 1'b0;
      tick();
   endtask

   task automatic exp_frame(input int ch, input int slot, input int n, input logic [7:0] seed,
                            input bit irq);
      wr_t e;
      for (int i = 0; i < n; i++) begin
         e.addr = {CH_W'(ch), 1'(slot), AW'(i)};
         e.data = seed + 8'(i);
         wq.push_back(e);
      end
      if (irq) iq.push_back(ch);
   endtask

   // Drives n bytes then one low cycle; optionally pulses rd_done in that end cycle.
   task automatic send_frame(input logic [15:0] port, input int n, input int err_at,
                             input logic [7:0] seed, input bit done_at_end);
      for (int i = 0; i < n; i++) begin
         rx_dst_port   = port;
         rx_udp_data_v = 1'b1;
         rx_udp_data   = seed + 8'(i);
         rx_udp_err    = (i == err_at);
         tick();
      end
      rx_udp_data_v = 1'b0;
      rx_udp_err    = 1'b0;
      rd_done       = done_at_end;
      tick();
      rd_done = 1'b0;
   endtask

   task automatic release_slot(input int ch);
      rd_ch   = CH_W'(ch);
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset();
      @(negedge RX_CLK);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_ch_avail", 32'(ch_avail), 0);
      chk("rst_ch_irq", 32'(ch_irq), 0);
      chk("rst_drop_cnt", 32'(drop_cnt), 0);
      chk("rst_rd_slot", 32'(rd_slot), 0);
      chk("rst_rd_len", 32'(rd_len), 0);

      // Basic 64-byte commit on channel 1
      ch_port[16*1 +: 16] = 16'd5000;
      ch_en = 4'b0010;
      rd_ch = 2'd1;
      exp_frame(1, 0, 64, 8'h00, 1'b1);
      send_frame(16'd5000, 64, -1, 8'h00, 1'b0);
      @(negedge RX_CLK);
      chk("basic_irq_timing", 32'(ch_irq), 32'h2);
      chk("basic_avail", 32'(ch_avail), 32'h2);
      chk("basic_rd_len", 32'(rd_len), 64);
      chk("basic_rd_slot", 32'(rd_slot), 0);

      // Slot overflow: two back-to-back commits then a drop
      apply_reset();
      exp_frame(1, 0, 10, 8'h10, 1'b1);
      send_frame(16'd5000, 10, -1, 8'h10, 1'b0);
      exp_frame(1, 1, 10, 8'h20, 1'b1);
      send_frame(16'd5000, 10, -1, 8'h20, 1'b0);
      send_frame(16'd5000, 10, -1, 8'h30, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("ovf_drop_cnt", 32'(drop_cnt), 1);
      chk("ovf_rd_slot", 32'(rd_slot), 0);
      release_slot(1);
      @(negedge RX_CLK);
      chk("ovf_rd_slot_after_done", 32'(rd_slot), 1);
      chk("ovf_avail_after_done", 32'(ch_avail), 32'h2);
      chk("ovf_rd_len_after_done", 32'(rd_len), 10);

      // Error drop, then the next good frame reuses slot 0
      apply_reset();
      exp_frame(1, 0, 20, 8'h40, 1'b0);
      send_frame(16'd5000, 20, 7, 8'h40, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("err_drop_cnt", 32'(drop_cnt), 1);
      chk("err_no_avail", 32'(ch_avail), 0);
      exp_frame(1, 0, 12, 8'h60, 1'b1);
      send_frame(16'd5000, 12, -1, 8'h60, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("err_reuse_slot", 32'(rd_slot), 0);
      chk("err_reuse_len", 32'(rd_len), 12);

      // Length boundary on the 16-byte-slot instance
      ch_en = 4'b0000;
      ch_en_s = 4'b0010;
      apply_reset();
      s_we_cnt = 0;
      s_irq_cnt = 0;
      send_frame(16'd5000, 16, -1, 8'h00, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("len16_writes", 32'(s_we_cnt), 16);
      chk("len16_irq", 32'(s_irq_cnt), 1);
      chk("len16_rd_len", 32'(rd_len_s), 16);
      send_frame(16'd5000, 17, -1, 8'h00, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("len17_writes", 32'(s_we_cnt), 32);
      chk("len17_no_irq", 32'(s_irq_cnt), 1);
      chk("len17_drop_cnt", 32'(drop_cnt_s), 1);
      chk("len17_avail", 32'(ch_avail_s), 32'h2);
      chk("len_main_untouched", 32'(drop_cnt), 0);
      ch_en_s = 4'b0000;

      // Priority match and no-match, including a 1-byte frame
      apply_reset();
      ch_port[16*0 +: 16] = 16'd53;
      ch_port[16*2 +: 16] = 16'd53;
      ch_en = 4'b0101;
      rd_ch = 2'd0;
      exp_frame(0, 0, 1, 8'hA5, 1'b1);
      send_frame(16'd53, 1, -1, 8'hA5, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("prio_avail", 32'(ch_avail), 32'h1);
      chk("prio_rd_len", 32'(rd_len), 1);
      send_frame(16'd54, 3, -1, 8'hC0, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("nomatch_drop_cnt", 32'(drop_cnt), 0);
      chk("nomatch_avail", 32'(ch_avail), 32'h1);

      // rd_done in the same cycle as a commit on the same channel
      apply_reset();
      ch_en = 4'b0010;
      rd_ch = 2'd1;
      exp_frame(1, 0, 4, 8'h70, 1'b1);
      send_frame(16'd5000, 4, -1, 8'h70, 1'b0);
      exp_frame(1, 1, 6, 8'h80, 1'b1);
      send_frame(16'd5000, 6, -1, 8'h80, 1'b1);
      idle(1);
      @(negedge RX_CLK);
      chk("simul_rd_slot", 32'(rd_slot), 1);
      chk("simul_rd_len", 32'(rd_len), 6);
      chk("simul_avail", 32'(ch_avail), 32'h2);
      release_slot(1);
      @(negedge RX_CLK);
      chk("simul_all_released", 32'(ch_avail), 0);

      // Reset in the middle of a frame: tail is ignored, nothing committed
      exp_frame(1, 0, 3, 8'h90, 1'b0);
      for (int i = 0; i < 7; i++) begin
         if (i == 3) rst = 1'b1;
         if (i == 5) rst = 1'b0;
         rx_dst_port   = 16'd5000;
         rx_udp_data_v = 1'b1;
         rx_udp_data   = 8'h90 + 8'(i);
         tick();
         if (i == 5) begin
            @(negedge RX_CLK);
            chk("midrst_mem_we", 32'(mem_we), 0);
            chk("midrst_mem_addr", 32'(mem_addr), 0);
            chk("midrst_irq", 32'(ch_irq), 0);
            chk("midrst_avail", 32'(ch_avail), 0);
            chk("midrst_drop_cnt", 32'(drop_cnt), 0);
         end
      end
      rx_udp_data_v = 1'b0;
      idle(3);
      @(negedge RX_CLK);
      chk("midrst_after_avail", 32'(ch_avail), 0);
      chk("midrst_after_drop", 32'(drop_cnt), 0);
      exp_frame(1, 0, 2, 8'hB0, 1'b1);
      send_frame(16'd5000, 2, -1, 8'hB0, 1'b0);
      idle(1);
      @(negedge RX_CLK);
      chk("recover_rd_len", 32'(rd_len), 2);

      idle(3);
      @(negedge RX_CLK);
      chk("writes_drained", 32'(wq.size()), 0);
      chk("irqs_drained", 32'(iq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
